// File: rtl/bubble_ctrl_sequencer.sv
// Host-side bubble control sequencer: boot / page-read / swap access timing.
// Optional feature macro: BUBBLE_SEQ_ABORT_EN (adds the ABORT input).
module bubble_ctrl_sequencer #(
    parameter int CYCLE_CLKS  = 480,
    parameter int INIT_POS    = 1955,
    parameter int SETUP_CLKS  = 48,
    parameter int BSS_CLKS    = 48,
    parameter int GAP_CLKS    = 96,
    parameter int PULSE_CLKS  = 48,
    parameter int BOOT_CYCLES = 4204,
    parameter int PAGE_CYCLES = 682,
    parameter int SWAP_CYCLES = 16,
    parameter int GUARD_CLKS  = 480
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_TYPE,
    input  logic [11:0] CMD_POS,
`ifdef BUBBLE_SEQ_ABORT_EN
    input  logic        ABORT,
`endif
    output logic        nINCTRL,
    output logic        nBSS,
    output logic        nBSEN,
    output logic        nREPEN,
    output logic        nBOOTEN,
    output logic        nSWAPEN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [11:0] CURPOS
);
    localparam logic [11:0] POS_MAX = 12'd2052;
    localparam logic [1:0]  T_BOOT = 2'b00, T_PAGE = 2'b01, T_SWAP = 2'b10, T_ILL = 2'b11;

    // S_ERR and S_DONE are single-clock states that carry the ERR / DONE pulses.
    typedef enum logic [3:0] {
        S_IDLE, S_ERR, S_SETUP, S_STROBE, S_GAP, S_RUN, S_PULSE, S_HOLD, S_RELEASE, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt, cyc, cyc_nxt, wraps, wraps_nxt, hold_cycles;
    logic [11:0] pos_nxt, pos_inc, tgt, tgt_nxt;
    logic [1:0]  typ, typ_nxt;
    logic        wrap, abort;
    logic        ctl_active, ctl_run, ctl_boot;

`ifdef BUBBLE_SEQ_ABORT_EN
    assign abort = ABORT;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cyc    <= '0;
            wraps  <= '0;
            typ    <= T_BOOT;
            tgt    <= '0;
            CURPOS <= 12'(INIT_POS);
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            cyc    <= cyc_nxt;
            wraps  <= wraps_nxt;
            typ    <= typ_nxt;
            tgt    <= tgt_nxt;
            CURPOS <= pos_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 16'd1;
        cyc_nxt     = cyc;
        wraps_nxt   = wraps;
        pos_nxt     = CURPOS;
        typ_nxt     = typ;
        tgt_nxt     = tgt;
        wrap        = (cyc == 16'(CYCLE_CLKS - 1));
        pos_inc     = (CURPOS >= POS_MAX) ? 12'd0 : CURPOS + 12'd1;
        hold_cycles = (typ == T_SWAP) ? 16'(SWAP_CYCLES) : 16'(PAGE_CYCLES);

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (CMD_VALID && CMD_READY) begin
                    typ_nxt = CMD_TYPE;
                    tgt_nxt = CMD_POS;
                    if (CMD_TYPE == T_ILL || (CMD_TYPE != T_BOOT && CMD_POS > POS_MAX))
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_SETUP;
                end
            end
            S_ERR: state_nxt = S_IDLE;
            S_SETUP: if (cnt == 16'(SETUP_CLKS - 1)) begin
                state_nxt = S_STROBE;
                cnt_nxt   = '0;
            end
            S_STROBE: if (cnt == 16'(BSS_CLKS - 1)) begin
                state_nxt = S_GAP;
                cnt_nxt   = '0;
            end
            S_GAP: if (cnt == 16'(GAP_CLKS - 1)) begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
                cyc_nxt   = '0;
                wraps_nxt = '0;
            end
            S_RUN, S_PULSE, S_HOLD: begin
                cyc_nxt = wrap ? 16'd0 : cyc + 16'd1;
                if (wrap) begin
                    pos_nxt   = pos_inc;
                    wraps_nxt = wraps + 16'd1;
                end
                // Target compare only on an increment, so a target equal to the
                // starting position costs a full revolution.
                if (state == S_RUN) begin
                    if (wrap && typ == T_BOOT && wraps_nxt == 16'(BOOT_CYCLES)) begin
                        state_nxt = S_RELEASE;
                        cnt_nxt   = '0;
                    end else if (wrap && typ != T_BOOT && pos_inc == tgt) begin
                        state_nxt = S_PULSE;
                        cnt_nxt   = '0;
                        wraps_nxt = '0;
                    end
                end else if (wrap && wraps_nxt == hold_cycles) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = '0;
                end else if (state == S_PULSE && cnt == 16'(PULSE_CLKS - 1)) begin
                    state_nxt = S_HOLD;
                end
            end
            S_RELEASE: if (cnt == 16'(GUARD_CLKS - 1)) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        if (abort && (state inside {S_SETUP, S_STROBE, S_GAP, S_RUN, S_PULSE, S_HOLD})) begin
            state_nxt = S_RELEASE;
            cnt_nxt   = '0;
            pos_nxt   = CURPOS;
        end

        ctl_active = state_nxt inside {S_SETUP, S_STROBE, S_GAP, S_RUN, S_PULSE, S_HOLD, S_RELEASE};
        ctl_run    = state_nxt inside {S_RUN, S_PULSE, S_HOLD};
        ctl_boot   = (typ_nxt == T_BOOT) &&
                     (state_nxt inside {S_SETUP, S_STROBE, S_GAP, S_RUN});
    end

    // Outputs are decoded from the next state and registered.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            nINCTRL   <= 1'b1;
            nBSS      <= 1'b1;
            nBSEN     <= 1'b1;
            nREPEN    <= 1'b1;
            nBOOTEN   <= 1'b1;
            nSWAPEN   <= 1'b1;
            CMD_READY <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            nINCTRL   <= !ctl_active;
            nBSS      <= (state_nxt != S_STROBE);
            nBSEN     <= !ctl_run;
            nREPEN    <= !(state_nxt == S_PULSE && typ_nxt == T_PAGE);
            nBOOTEN   <= !ctl_boot;
            nSWAPEN   <= !(state_nxt == S_PULSE && typ_nxt == T_SWAP);
            CMD_READY <= (state_nxt == S_IDLE);
            BUSY      <= (state_nxt != S_IDLE);
            DONE      <= (state_nxt == S_DONE);
            ERR       <= (state_nxt == S_ERR);
        end
    end
endmodule
